lerp2_multi: RTL and testbench

- Multi-channel bilinear interpolator for the voxel shading path.
- Computes normalised weights fx = x/X and fy = y/Y once, using a single shared iterative divider. It then blends the four corner values of every channel in turn, using one shared multiplier datapath.
- Replaces the three-parallel-divider bilinear block. Adds channel count, weight clamping, divide-by-zero reporting, busy/done handshake and input latching.

---
 rtl/lerp2_multi.sv | 209 ++++++++++++++++++++
 tb/tb_lerp2_multi.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lerp2_multi.sv
// lerp2_multi: multi-channel bilinear interpolator.
// One shared restoring divider for the weights, one shared blend path.
module lerp2_multi #(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 16,
  parameter int CHANNELS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CHANNELS*WIDTH-1:0] p0,
  input  logic [CHANNELS*WIDTH-1:0] p1,
  input  logic [CHANNELS*WIDTH-1:0] p2,
  input  logic [CHANNELS*WIDTH-1:0] p3,
  input  logic signed [WIDTH-1:0]   x,
  input  logic signed [WIDTH-1:0]   y,
  input  logic signed [WIDTH-1:0]   X,
  input  logic signed [WIDTH-1:0]   Y,
  output logic [CHANNELS*WIDTH-1:0] val,
  output logic                      busy,
  output logic                      done,
  output logic                      dbz
);

  localparam int NW = CHANNELS * WIDTH;
  localparam int RW = WIDTH + 1;
  localparam int WW = FBITS + 1;
  localparam int DW = WIDTH + 2;
  localparam int PW = DW + FBITS + 2;
  localparam int KW = $clog2(FBITS + 1);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DIVX, S_DIVY, S_MIX, S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [NW-1:0] p0_q, p1_q, p2_q, p3_q;
  logic [NW-1:0] val_q;
  logic signed [WIDTH-1:0] xn_q, yn_q, xd_q, yd_q;
  logic [RW-1:0] rem_q;
  logic [FBITS-1:0] quo_q;
  logic [KW-1:0] cnt_q;
  logic [CW-1:0] ch_q;
  logic [WW-1:0] fx_q, fy_q, fxy_q;
  logic dbz_q;

  logic div_last, mix_last;
  logic signed [WIDTH-1:0] num_s, den_s;
  logic [RW-1:0] den_r, shl, rem_nx;
  logic qbit;
  logic [FBITS-1:0] quo_nx;
  logic [WW-1:0] wt_s, fxy_s;
  logic [2*WW-1:0] pxy;

  logic signed [DW-1:0] a0, a1, a2, a3, db, dc, dd;
  logic signed [PW-1:0] wx, wy, wxy, mb, mc, md, sum;
  logic [WIDTH-1:0] res;

  assign div_last = (cnt_q == KW'(FBITS - 1));
  assign mix_last = (ch_q == CW'(CHANNELS - 1));

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)    state_d = S_DIVX;
      S_DIVX: if (div_last) state_d = S_DIVY;
      S_DIVY: if (div_last) state_d = S_MIX;
      S_MIX:  if (mix_last) state_d = S_FIN;
      S_FIN:                state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == S_DIVX),
      (state_q == S_DIVY),
      (state_q == S_MIX): busy = 1'b1;
      (state_q == S_FIN): done = 1'b1;
      default: ;
    endcase
  end

  // one restoring-divider step plus the clamp rules for the weight
  always_comb begin
    num_s  = (state_q == S_DIVY) ? yn_q : xn_q;
    den_s  = (state_q == S_DIVY) ? yd_q : xd_q;
    den_r  = {1'b0, den_s};
    shl    = rem_q << 1;
    qbit   = (shl >= den_r);
    rem_nx = qbit ? (shl - den_r) : shl;
    quo_nx = FBITS'({quo_q, qbit});
    if (den_s <= 0 || num_s <= 0)
      wt_s = '0;
    else if (num_s >= den_s)
      wt_s = WW'(1) << FBITS;
    else
      wt_s = {1'b0, quo_nx};
    pxy   = (2*WW)'(fx_q) * (2*WW)'(wt_s);
    fxy_s = WW'(pxy >> FBITS);
  end

  // blend of the channel selected by ch_q
  always_comb begin
    a0  = DW'($signed(p0_q[ch_q*WIDTH +: WIDTH]));
    a1  = DW'($signed(p1_q[ch_q*WIDTH +: WIDTH]));
    a2  = DW'($signed(p2_q[ch_q*WIDTH +: WIDTH]));
    a3  = DW'($signed(p3_q[ch_q*WIDTH +: WIDTH]));
    db  = a1 - a0;
    dc  = a2 - a0;
    dd  = a0 - a1 + a3 - a2;
    wx  = PW'({1'b0, fx_q});
    wy  = PW'({1'b0, fy_q});
    wxy = PW'({1'b0, fxy_q});
    mb  = PW'(db) * wx;
    mc  = PW'(dc) * wy;
    md  = PW'(dd) * wxy;
    sum = PW'(a0) + (mb >>> FBITS)
        + (mc >>> FBITS) + (md >>> FBITS);
    res = WIDTH'(sum);
  end

  // latches, divider, weights, channel walk and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p0_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      p3_q  <= '0;
      xn_q  <= '0;
      yn_q  <= '0;
      xd_q  <= '0;
      yd_q  <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      ch_q  <= '0;
      fx_q  <= '0;
      fy_q  <= '0;
      fxy_q <= '0;
      val_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            p0_q  <= p0;
            p1_q  <= p1;
            p2_q  <= p2;
            p3_q  <= p3;
            xn_q  <= x;
            yn_q  <= y;
            xd_q  <= X;
            yd_q  <= Y;
            rem_q <= {1'b0, x};
            quo_q <= '0;
            cnt_q <= '0;
            ch_q  <= '0;
            dbz_q <= 1'b0;
          end
        end
        S_DIVX: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + KW'(1);
          if (div_last) begin
            fx_q  <= wt_s;
            rem_q <= {1'b0, yn_q};
            quo_q <= '0;
            cnt_q <= '0;
            if (xd_q <= 0) dbz_q <= 1'b1;
          end
        end
        S_DIVY: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + KW'(1);
          if (div_last) begin
            fy_q  <= wt_s;
            fxy_q <= fxy_s;
            cnt_q <= '0;
            if (yd_q <= 0) dbz_q <= 1'b1;
          end
        end
        S_MIX: begin
          val_q[ch_q*WIDTH +: WIDTH] <= res;
          ch_q <= ch_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign val = val_q;
  assign dbz = dbz_q;

endmodule

// File: tb/tb_lerp2_multi.sv
// tb_lerp2_multi: directed and random requests against
// an arithmetic model of the bilinear blend.
module tb_lerp2_multi;

  localparam int W   = 32;
  localparam int F   = 16;
  localparam int CH  = 3;
  localparam int NW  = CH * W;
  localparam int LAT = 2 * F + CH + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [NW-1:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic signed [W-1:0] x = '0, y = '0, X = '0, Y = '0;
  logic [NW-1:0] val;
  logic busy, done, dbz;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  lerp2_multi #(.WIDTH(W), .FBITS(F), .CHANNELS(CH)) dut (
    .clock(clock), .reset(reset), .start(start),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .x(x), .y(y), .X(X), .Y(Y),
    .val(val), .busy(busy), .done(done), .dbz(dbz)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint wt(longint n, longint d);
    if (d <= 0 || n <= 0) return 0;
    if (n >= d) return longint'(1) << F;
    return (n << F) / d;
  endfunction

  function automatic logic [W-1:0] blend(longint a0, longint a1,
                                         longint a2, longint a3,
                                         longint fx, longint fy);
    longint fxy, r;
    fxy = (fx * fy) >> F;
    r = a0 + (((a1 - a0) * fx) >>> F)
           + (((a2 - a0) * fy) >>> F)
           + (((a0 - a1 + a3 - a2) * fxy) >>> F);
    return r[W-1:0];
  endfunction

  function automatic longint sx(logic [NW-1:0] v, int c);
    logic signed [W-1:0] t;
    t = v[c*W +: W];
    return longint'(t);
  endfunction

  task automatic scramble();
    p0 = {$urandom, $urandom, $urandom};
    p1 = {$urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom};
    p3 = {$urandom, $urandom, $urandom};
    x = $urandom; y = $urandom; X = $urandom; Y = $urandom;
  endtask

  task automatic set_all(int c0, int c1, int c2, int c3);
    for (int c = 0; c < CH; c++) begin
      p0[c*W +: W] = c0;
      p1[c*W +: W] = c1;
      p2[c*W +: W] = c2;
      p3[c*W +: W] = c3;
    end
  endtask

  // full request: start, optional ignored start at 'glitch', checks
  task automatic run(string tag, int glitch);
    logic [NW-1:0] e0, e1, e2, e3;
    longint fx, fy;
    logic edbz;
    int n, lowbusy;
    e0 = p0; e1 = p1; e2 = p2; e3 = p3;
    fx = wt(longint'(x), longint'(X));
    fy = wt(longint'(y), longint'(Y));
    edbz = (X <= 0) || (Y <= 0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    scramble();
    n = 1;
    lowbusy = busy ? 0 : 1;
    while (!done && n < LAT + 10) begin
      if (n == glitch) begin
        start = 1'b1;
        scramble();
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      n++;
      if (!done && !busy) lowbusy++;
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_busygap"}, lowbusy, 0);
    chk({tag, "_busyfin"}, busy, 1'b0);
    for (int c = 0; c < CH; c++)
      chk({tag, "_val"}, val[c*W +: W],
          blend(sx(e0, c), sx(e1, c), sx(e2, c), sx(e3, c), fx, fy));
    chk({tag, "_dbz"}, dbz, edbz);
    @(posedge clock);
    #1;
    chk({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    int dcnt;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_val", val, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", dbz, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    set_all(0, 'h10000, 'h20000, 'h30000);
    x = 1; X = 2; y = 1; Y = 2;
    run("mid", 0);
    for (int c = 0; c < CH; c++)
      chk("mid_const", val[c*W +: W], 32'h18000);

    for (int c = 0; c < CH; c++) begin
      p0[c*W +: W] = 32'h1000 + c * 32'h100;
      p1[c*W +: W] = 32'h5000 + c * 32'h100;
      p2[c*W +: W] = 32'h9000 + c * 32'h100;
      p3[c*W +: W] = 32'hD000 + c * 32'h100;
    end
    x = 0; y = 0; X = 7; Y = 9;
    run("c00", 0);
    chk("c00_p0", val[W-1:0], 32'h1000);
    for (int c = 0; c < CH; c++) begin
      p0[c*W +: W] = 32'h1000 + c * 32'h100;
      p1[c*W +: W] = 32'h5000 + c * 32'h100;
      p2[c*W +: W] = 32'h9000 + c * 32'h100;
      p3[c*W +: W] = 32'hD000 + c * 32'h100;
    end
    x = 7; y = 9; X = 7; Y = 9;
    run("cXY", 0);
    chk("cXY_p3", val[2*W +: W], 32'hD200);

    set_all(0, 'h40000, 0, 'h40000);
    x = -5; X = 4; y = 0; Y = 1;
    run("clo", 0);
    chk("clo_const", val[W-1:0], 32'h0);
    set_all(0, 'h40000, 0, 'h40000);
    x = 10; X = 4; y = 0; Y = 1;
    run("chi", 0);
    chk("chi_const", val[W-1:0], 32'h40000);

    set_all(0, 0, 'h20000, 'h20000);
    x = 3; X = 0; y = 1; Y = 2;
    run("dbz", 0);
    chk("dbz_const", val[W-1:0], 32'h10000);
    chk("dbz_flag", dbz, 1'b1);
    set_all(0, 'h10000, 'h20000, 'h30000);
    x = 1; X = 2; y = 1; Y = 2;
    run("dbzclr", 0);

    set_all(-'h10000, 'h10000, -'h10000, 'h10000);
    x = 1; X = 4; y = 0; Y = 1;
    run("sgn", 0);
    chk("sgn_const", val[W-1:0], 32'hFFFF8000);

    set_all('h1234, 'h7777, -'h4000, 'h20000);
    x = 3; X = 5; y = 2; Y = 7;
    run("ign", 20);

    set_all(0, 'h10000, 'h20000, 'h30000);
    x = 1; X = 2; y = 1; Y = 2;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (33) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_val", val, '0);
    chk("arst_busy", busy, 1'b0);
    dcnt = done ? 1 : 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (done) dcnt++;
    end
    chk("arst_nodone", dcnt, 0);
    @(negedge clock);
    reset = 1'b1;
    set_all('h3000, -'h2000, 'h100, 'h7FFF);
    x = 5; X = 9; y = 4; Y = 11;
    run("post", 0);

    for (int i = 0; i < 20; i++) begin
      int mode;
      scramble();
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        x = $urandom_range(0, 24) - 4;
        X = $urandom_range(0, 18) - 2;
        y = $urandom_range(0, 24) - 4;
        Y = $urandom_range(0, 18) - 2;
      end else if (mode == 1) begin
        X = $urandom_range(1, 32'h7FFFFFFF);
        x = $urandom_range(0, X);
        Y = $urandom_range(1, 32'h7FFFFFFF);
        y = $urandom_range(0, Y);
      end
      run("rnd", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
